hazard_ctrl: RTL and testbench

//  Stall/flush/forward controller for the 5-stage pipeline (F,D,E,M,W). It enables the F/D registers
//  and clears the E_reg. It drives bypass selects into D, E and M.
//  It owns a multiply/divide busy timer so HI/LO users wait in D while an md op runs.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/md_busy_timer.sv | 40 ++++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and the bypass-select helper for the hazard controller.
package hazard_pkg;

  localparam int T_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  // M wins over W; register 0 is never bypassed. use_m=0 restricts to W only.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0]     a,
    input logic [4:0]     m_wa,
    input logic [T_W-1:0] m_tnew,
    input logic [4:0]     w_wa,
    input logic           use_m
  );
    if (a == 5'd0) return FWD_RF;
    if (use_m && (a == m_wa) && (m_tnew == '0)) return FWD_M;
    if (a == w_wa) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the op latency on a start, then counts down to idle.
module md_busy_timer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_VAL = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_VAL  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;

  // A start while the timer is running is illegal and simply ignored.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (start && (md_cnt_q == '0)) begin
      md_cnt_d = is_div ? DIV_VAL : MULT_VAL;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bypass controller for the 5-stage pipeline.
// Optional HAZARD_STALL_CNT_EN adds saturating stall_cnt / md_stall_cnt outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     D_rs,
  input  logic [4:0]     D_rt,
  input  logic [T_W-1:0] D_rs_tuse,
  input  logic [T_W-1:0] D_rt_tuse,
  input  logic           D_is_md,
  input  logic [4:0]     E_rs,
  input  logic [4:0]     E_rt,
  input  logic [4:0]     E_wa,
  input  logic [T_W-1:0] E_tnew,
  input  logic           E_md_start,
  input  logic           E_md_is_div,
  input  logic [4:0]     M_rt,
  input  logic [4:0]     M_wa,
  input  logic [T_W-1:0] M_tnew,
  input  logic [4:0]     W_wa,
  output logic           F_en,
  output logic           D_en,
  output logic           E_clr,
  output logic [1:0]     fwd_D_rs,
  output logic [1:0]     fwd_D_rt,
  output logic [1:0]     fwd_E_rs,
  output logic [1:0]     fwd_E_rt,
  output logic [1:0]     fwd_M_rt,
  output logic           md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [31:0]    md_stall_cnt
`endif
);

  logic rs_stall;
  logic rt_stall;
  logic md_stall;
  logic stall;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_is_div),
    .busy   (md_busy)
  );

  // A producer still needing more cycles than the consumer can wait forces D to hold.
  always_comb begin
    rs_stall = (D_rs != 5'd0) &&
               (((E_wa == D_rs) && (E_tnew > D_rs_tuse)) ||
                ((M_wa == D_rs) && (M_tnew > D_rs_tuse)));
    rt_stall = (D_rt != 5'd0) &&
               (((E_wa == D_rt) && (E_tnew > D_rt_tuse)) ||
                ((M_wa == D_rt) && (M_tnew > D_rt_tuse)));
    md_stall = D_is_md && (md_busy || E_md_start);
    stall    = rs_stall || rt_stall || md_stall;
  end

  assign F_en  = !stall;
  assign D_en  = !stall;
  assign E_clr = stall;

  assign fwd_D_rs = fwd_sel(D_rs, M_wa, M_tnew, W_wa, 1'b1);
  assign fwd_D_rt = fwd_sel(D_rt, M_wa, M_tnew, W_wa, 1'b1);
  assign fwd_E_rs = fwd_sel(E_rs, M_wa, M_tnew, W_wa, 1'b1);
  assign fwd_E_rt = fwd_sel(E_rt, M_wa, M_tnew, W_wa, 1'b1);
  assign fwd_M_rt = fwd_sel(M_rt, M_wa, M_tnew, W_wa, 1'b0);

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] md_stall_cnt_q;
  logic [31:0] md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    md_stall_cnt_d = md_stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (md_stall && (md_stall_cnt_q != 32'hFFFF_FFFF)) md_stall_cnt_d = md_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus multi-cycle timer sequences.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wa, M_rt, M_wa, W_wa;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_is_div;
  logic       F_en, D_en, E_clr, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_rs_tuse   (D_rs_tuse),
    .D_rt_tuse   (D_rt_tuse),
    .D_is_md     (D_is_md),
    .E_rs        (E_rs),
    .E_rt        (E_rt),
    .E_wa        (E_wa),
    .E_tnew      (E_tnew),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .M_rt        (M_rt),
    .M_wa        (M_wa),
    .M_tnew      (M_tnew),
    .W_wa        (W_wa),
    .F_en        (F_en),
    .D_en        (D_en),
    .E_clr       (E_clr),
    .fwd_D_rs    (fwd_D_rs),
    .fwd_D_rt    (fwd_D_rt),
    .fwd_E_rs    (fwd_E_rs),
    .fwd_E_rt    (fwd_E_rt),
    .fwd_M_rt    (fwd_M_rt),
    .md_busy     (md_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .md_stall_cnt(md_stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] d_rs, d_rt;
    logic [1:0] rs_tu, rt_tu;
    logic       is_md;
    logic [4:0] e_rs, e_rt, e_wa;
    logic [1:0] e_tn;
    logic [4:0] m_rt, m_wa;
    logic [1:0] m_tn;
    logic [4:0] w_wa;
    logic       stall;
    logic [1:0] f_drs, f_drt, f_ers, f_ert, f_mrt;
    string      name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".F_en"},  {31'd0, F_en},  {31'd0, !exp});
    chk({name, ".D_en"},  {31'd0, D_en},  {31'd0, !exp});
    chk({name, ".E_clr"}, {31'd0, E_clr}, {31'd0, exp});
  endtask

  task automatic set_idle();
    D_rs = 0; D_rt = 0; D_rs_tuse = TUSE_NONE; D_rt_tuse = TUSE_NONE; D_is_md = 0;
    E_rs = 0; E_rt = 0; E_wa = 0; E_tnew = 0; E_md_start = 0; E_md_is_div = 0;
    M_rt = 0; M_wa = 0; M_tnew = 0; W_wa = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  // lw in E (Tnew=2) feeding D rs (Tuse=1): one stall, then released once lw sits in M with Tnew=1.
  task automatic lw_seq(input string tag);
    @(negedge clk); set_idle();
    E_wa = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_rs_tuse = 2'd1;
    #1; chk_stall({tag, ".lw_c0"}, 1'b1);
    @(negedge clk); set_idle();
    D_rs = 5'd1; D_rs_tuse = 2'd1; M_wa = 5'd1; M_tnew = 2'd1;
    #1; chk_stall({tag, ".lw_c1"}, 1'b0);
    $display("%s: lw stall sequence done", tag);
  endtask

  // mult in E with mflo in D: stall cycles 0..5, release in cycle 6.
  task automatic mult_seq(input string tag);
    @(negedge clk); set_idle();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b0;
    #1;
    chk({tag, ".idle_before_start"}, {31'd0, md_busy}, 32'd0);
    chk_stall({tag, ".mult_c0"}, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); E_md_start = 1'b0;
      #1;
      chk($sformatf("%s.md_busy_c%0d", tag, i), {31'd0, md_busy}, 32'd1);
      chk_stall($sformatf("%s.mult_c%0d", tag, i), 1'b1);
    end
    @(negedge clk); #1;
    chk({tag, ".md_busy_c6"}, {31'd0, md_busy}, 32'd0);
    chk_stall({tag, ".mult_c6"}, 1'b0);
    $display("%s: mult/mflo sequence done", tag);
  endtask

  initial begin
    int busy_n;

    //          d_rs d_rt rs_tu rt_tu md e_rs e_rt e_wa e_tn m_rt m_wa m_tn w_wa st  fdrs    fdrt    fers    fert    fmrt
    vecs[0]  = '{0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "idle"};
    vecs[1]  = '{1, 0, 1, 3, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "lw_hazard"};
    vecs[2]  = '{0, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "zero_guard"};
    vecs[3]  = '{0, 2, 3, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "tnew_eq_tuse"};
    vecs[4]  = '{0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "m_stall_rt"};
    vecs[5]  = '{0, 0, 3, 3, 0, 3, 0, 0, 0, 0, 3, 0, 3, 0, FWD_RF, FWD_RF, FWD_M,  FWD_RF, FWD_RF, "prio_m"};
    vecs[6]  = '{0, 0, 3, 3, 0, 3, 0, 0, 0, 0, 3, 1, 3, 0, FWD_RF, FWD_RF, FWD_W,  FWD_RF, FWD_RF, "prio_w"};
    vecs[7]  = '{0, 0, 3, 3, 0, 0, 5, 0, 0, 5, 5, 0, 5, 0, FWD_RF, FWD_RF, FWD_RF, FWD_M,  FWD_W,  "m_rt_w_only"};
    vecs[8]  = '{6, 7, 0, 3, 0, 0, 0, 0, 0, 0, 6, 0, 7, 0, FWD_M,  FWD_W,  FWD_RF, FWD_RF, FWD_RF, "d_fwd"};
    vecs[9]  = '{8, 0, 3, 3, 0, 0, 0, 8, 2, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "tuse_none"};
    vecs[10] = '{0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF, FWD_RF, "md_idle"};
    vecs[11] = '{0, 9, 3, 0, 0, 0, 0, 9, 1, 0, 0, 0, 9, 1, FWD_RF, FWD_W,  FWD_RF, FWD_RF, FWD_RF, "e_stall_rt"};

    set_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("reset", 1'b0);
    chk("reset.fwd_D_rs", {30'd0, fwd_D_rs}, {30'd0, FWD_RF});
    chk("reset.fwd_M_rt", {30'd0, fwd_M_rt}, {30'd0, FWD_RF});
    $display("reset: md_busy=%0b F_en=%0b", md_busy, F_en);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      D_rs = vecs[i].d_rs; D_rt = vecs[i].d_rt;
      D_rs_tuse = vecs[i].rs_tu; D_rt_tuse = vecs[i].rt_tu; D_is_md = vecs[i].is_md;
      E_rs = vecs[i].e_rs; E_rt = vecs[i].e_rt; E_wa = vecs[i].e_wa; E_tnew = vecs[i].e_tn;
      E_md_start = 1'b0; E_md_is_div = 1'b0;
      M_rt = vecs[i].m_rt; M_wa = vecs[i].m_wa; M_tnew = vecs[i].m_tn; W_wa = vecs[i].w_wa;
      #1;
      chk_stall(vecs[i].name, vecs[i].stall);
      chk({vecs[i].name, ".fwd_D_rs"}, {30'd0, fwd_D_rs}, {30'd0, vecs[i].f_drs});
      chk({vecs[i].name, ".fwd_D_rt"}, {30'd0, fwd_D_rt}, {30'd0, vecs[i].f_drt});
      chk({vecs[i].name, ".fwd_E_rs"}, {30'd0, fwd_E_rs}, {30'd0, vecs[i].f_ers});
      chk({vecs[i].name, ".fwd_E_rt"}, {30'd0, fwd_E_rt}, {30'd0, vecs[i].f_ert});
      chk({vecs[i].name, ".fwd_M_rt"}, {30'd0, fwd_M_rt}, {30'd0, vecs[i].f_mrt});
      chk({vecs[i].name, ".md_busy"},  {31'd0, md_busy},  32'd0);
      $display("vec %0d %s: F_en=%0b fwd=%0d/%0d/%0d/%0d/%0d", i, vecs[i].name, F_en,
               fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt);
    end

    lw_seq("seq1");
    mult_seq("seq3");

    // Divide latency: busy must hold for exactly DIV_LAT cycles.
    @(negedge clk); set_idle(); E_md_start = 1'b1; E_md_is_div = 1'b1;
    #1; chk("div.idle_before_start", {31'd0, md_busy}, 32'd0);
    busy_n = 0;
    repeat (20) begin
      @(negedge clk); E_md_start = 1'b0;
      #1; if (md_busy) busy_n++;
    end
    chk("div.busy_cycles", busy_n, 32'd10);
    $display("div: busy for %0d cycles", busy_n);

    // Reset while div counter reads 7; pending mfhi released the next cycle.
    @(negedge clk); set_idle(); E_md_start = 1'b1; E_md_is_div = 1'b1;
    repeat (3) begin
      @(negedge clk); E_md_start = 1'b0;
    end
    @(negedge clk); reset = 1'b0; D_is_md = 1'b1;
    #1;
    chk("rst_div.md_busy_cnt7", {31'd0, md_busy}, 32'd1);
    chk_stall("rst_div.cnt7", 1'b1);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rst_div.md_busy_after", {31'd0, md_busy}, 32'd0);
    chk_stall("rst_div.after", 1'b0);
    $display("reset mid-div: md_busy=%0b D_en=%0b", md_busy, D_en);

`ifdef HAZARD_STALL_CNT_EN
    do_reset();
    #1;
    chk("cnt.stall_after_reset", stall_cnt, 32'd0);
    chk("cnt.md_after_reset", md_stall_cnt, 32'd0);
    lw_seq("cnt_lw0");
    lw_seq("cnt_lw1");
    lw_seq("cnt_lw2");
    mult_seq("cnt_mult");
    chk("cnt.stall_cnt", stall_cnt, 32'd9);
    chk("cnt.md_stall_cnt", md_stall_cnt, 32'd6);
    $display("counters: stall_cnt=%0d md_stall_cnt=%0d", stall_cnt, md_stall_cnt);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
